timecode_tx: RTL and testbench

//  Serial transmitter for the RTC epoch. On each one_hz tick, captures the 64-bit

---
 rtl/timecode_pkg.sv | 31 +++
 rtl/timecode_bit_timer.sv | 42 ++++
 rtl/timecode_tx.sv | 161 ++++++++++++++++
 tb/tb_timecode_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timecode_pkg.sv
// Shared types and constants for the RTC timecode serial transmitter.
// Build with TIMECODE_PARITY_EN defined to append an even-parity bit after the data bits.
package timecode_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam int TIME_W_DEFAULT = 64;

`ifdef TIMECODE_PARITY_EN
  localparam int FRAME_OVERHEAD = 3;
`else
  localparam int FRAME_OVERHEAD = 2;
`endif

  localparam int FRAME_BITS = TIME_W_DEFAULT + FRAME_OVERHEAD;

  function automatic int frame_bits(input int time_w);
    return time_w + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/timecode_bit_timer.sv
// Bit-period timer: counts BIT_CLKS cycles per serial bit while a frame is active.
// bit_end marks the last cycle of a bit; pre_end marks the cycle before it.
module timecode_bit_timer #(
  parameter int BIT_CLKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(BIT_CLKS - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !active) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = active && (cnt_q == LAST_CNT);
  assign pre_end = active && (cnt_q == PRE_CNT);

endmodule

// File: rtl/timecode_tx.sv
// Serial transmitter for the RTC epoch: captures i_time on an accepted one_hz tick and
// sends START, TIME_W data bits LSB first, optional PARITY (TIMECODE_PARITY_EN), STOP.
//
// state  | meaning
// IDLE   | line high, waiting for one_hz & enable
// START  | start bit (line low)
// DATA   | data bits, shreg_q[0] on the line
// PARITY | even parity of the captured word (TIMECODE_PARITY_EN builds only)
// STOP   | stop bit (line high); frame_done on its last cycle
module timecode_tx
  import timecode_pkg::*;
#(
  parameter int BASE_FREQ = 1024,
  parameter int BIT_CLKS  = 8,
  parameter int TIME_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              one_hz,
  input  logic [TIME_W-1:0] i_time,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int BW = (TIME_W > 1) ? $clog2(TIME_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(TIME_W - 1);

  if (frame_bits(TIME_W) * BIT_CLKS >= BASE_FREQ) begin : g_bad_frame_len
    $error("timecode_tx: frame does not fit in one second");
  end
  if (BIT_CLKS < 2) begin : g_bad_bit_clks
    $error("timecode_tx: BIT_CLKS must be at least 2");
  end

  state_e            state_q, state_d;
  logic [TIME_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              start_frame;
  logic              bit_end;
  logic              pre_end;
  logic              parity_bit;

  assign start_frame = (state_q == IDLE) && one_hz && enable;

  timecode_bit_timer #(
    .BIT_CLKS (BIT_CLKS)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (state_q != IDLE),
    .clear   (start_frame),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

`ifdef TIMECODE_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = start_frame ? ^i_time : parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_bit = parity_d;
`else
  assign parity_bit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          shreg_d   = i_time;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef TIMECODE_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
          end
        end
      end
`ifdef TIMECODE_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx comes straight off a flop.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      IDLE:    tx_d = LINE_IDLE;
      START:   tx_d = LINE_START;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_bit;
      STOP:    tx_d = LINE_STOP;
      default: tx_d = LINE_IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == STOP) && pre_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= LINE_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  // Flags the dropped tick in the same cycle it arrives.
  assign overrun    = one_hz && (state_q != IDLE);

endmodule

// File: tb/tb_timecode_tx.sv
// Directed self-checking bench for timecode_tx; frame length follows TIMECODE_PARITY_EN.
module tb_timecode_tx;

  localparam int TIME_W   = 64;
  localparam int BIT_CLKS = 8;
`ifdef TIMECODE_PARITY_EN
  localparam int FB = 67;
`else
  localparam int FB = 66;
`endif
  localparam int FRAME_CYC = FB * BIT_CLKS;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        one_hz;
  logic [63:0] i_time;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  logic        cap [0:FB-1];
  logic [63:0] word;
  int          done_cyc, done_cnt, ovr_cyc, ovr_cnt;
  bit          stable_err, busy_err;

  timecode_tx #(
    .BASE_FREQ (1024),
    .BIT_CLKS  (BIT_CLKS),
    .TIME_W    (TIME_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .one_hz     (one_hz),
    .i_time     (i_time),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one frame (one_hz in cycle N) and records every cycle N+1..N+FRAME_CYC+1.
  task automatic run_frame(input logic [63:0] t, input int ovr_at, input bit scramble,
                           input int en_drop_at);
    done_cyc = -1; done_cnt = 0; ovr_cyc = -1; ovr_cnt = 0;
    stable_err = 0; busy_err = 0;
    tick();
    i_time = t;
    one_hz = 1'b1;
    enable = 1'b1;
    for (int c = 1; c <= FRAME_CYC + 1; c++) begin
      tick();
      one_hz = (c == ovr_at);
      if (scramble) i_time = {$urandom, $urandom};
      if (c == en_drop_at) enable = 1'b0;
      @(negedge clk);
      if (c <= FRAME_CYC) begin
        if ((c - 1) % BIT_CLKS == 0) cap[(c - 1) / BIT_CLKS] = tx;
        else if (tx !== cap[(c - 1) / BIT_CLKS]) stable_err = 1;
        if (busy !== 1'b1) busy_err = 1;
      end else if (busy !== 1'b0) begin
        busy_err = 1;
      end
      if (frame_done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (overrun === 1'b1) begin ovr_cnt++; ovr_cyc = c; end
    end
    one_hz = 1'b0;
    for (int i = 0; i < TIME_W; i++) word[i] = cap[1 + i];
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; one_hz = 1'b0; i_time = '0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({tx, busy, frame_done, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=1000", {tx, busy, frame_done, overrun});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    tick();
    i_time = 64'h1234_5678_9ABC_DEF0; one_hz = 1'b1; enable = 1'b1;
    tick();
    one_hz = 1'b0;
    repeat (200) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy got=%b exp=1", busy);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, busy, frame_done, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_frame got=%b exp=1000", {tx, busy, frame_done, overrun});
    end
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=10", {tx, busy});
    end
  endtask

  task automatic test_frame();
    run_frame(64'h0000_0000_5F5E_1001, -1, 1'b0, -1);
    checks++;
    if ({cap[0], cap[1], cap[2], cap[13]} !== 4'b0101) begin
      errors++;
      $display("FAIL frame_lead_bits got=%b exp=0101", {cap[0], cap[1], cap[2], cap[13]});
    end
    checks++;
    if (word !== 64'h0000_0000_5F5E_1001) begin
      errors++;
      $display("FAIL frame_word got=%h exp=%h", word, 64'h0000_0000_5F5E_1001);
    end
    checks++;
    if (cap[FB-1] !== 1'b1) begin
      errors++;
      $display("FAIL frame_stop got=%b exp=1", cap[FB-1]);
    end
    checks++;
    if (done_cyc !== FRAME_CYC || done_cnt !== 1) begin
      errors++;
      $display("FAIL frame_done_pos got=%0d/%0d exp=%0d/1", done_cyc, done_cnt, FRAME_CYC);
    end
    checks++;
    if (ovr_cnt !== 0 || stable_err || busy_err) begin
      errors++;
      $display("FAIL frame_shape got=ovr%0d stable%0d busy%0d exp=0 0 0",
               ovr_cnt, stable_err, busy_err);
    end
  endtask

`ifdef TIMECODE_PARITY_EN
  task automatic test_parity();
    run_frame(64'h1, -1, 1'b0, -1);
    checks++;
    if (cap[65] !== 1'b1 || cap[66] !== 1'b1) begin
      errors++;
      $display("FAIL parity_one got=%b%b exp=11", cap[65], cap[66]);
    end
    run_frame(64'h3, -1, 1'b0, -1);
    checks++;
    if (cap[65] !== 1'b0) begin
      errors++;
      $display("FAIL parity_three got=%b exp=0", cap[65]);
    end
    run_frame(64'h0, -1, 1'b0, -1);
    checks++;
    if (cap[65] !== 1'b0 || word !== 64'h0) begin
      errors++;
      $display("FAIL parity_zero got=%b word=%h exp=0 word=0", cap[65], word);
    end
  endtask
`endif

  task automatic test_overrun();
    run_frame(64'hDEAD_BEEF_0123_4567, 100, 1'b0, -1);
    checks++;
    if (ovr_cnt !== 1 || ovr_cyc !== 100) begin
      errors++;
      $display("FAIL overrun_mid got=%0d@%0d exp=1@100", ovr_cnt, ovr_cyc);
    end
    checks++;
    if (word !== 64'hDEAD_BEEF_0123_4567 || done_cyc !== FRAME_CYC) begin
      errors++;
      $display("FAIL overrun_frame got=%h@%0d exp=%h@%0d", word, done_cyc,
               64'hDEAD_BEEF_0123_4567, FRAME_CYC);
    end
    run_frame(64'h0000_0000_0000_00A5, FRAME_CYC, 1'b0, -1);
    checks++;
    if (ovr_cnt !== 1 || ovr_cyc !== FRAME_CYC || busy_err) begin
      errors++;
      $display("FAIL overrun_on_done got=%0d@%0d busy_err=%0d exp=1@%0d busy_err=0",
               ovr_cnt, ovr_cyc, busy_err, FRAME_CYC);
    end
  endtask

  task automatic test_enable();
    bit bad;
    bad = 0;
    tick();
    enable = 1'b0;
    one_hz = 1'b1;
    @(negedge clk);
    if (overrun !== 1'b0) bad = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      one_hz = 1'b0;
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL enable_low_ignored got=tx%b busy%b ovr%b exp=tx1 busy0 ovr0",
               tx, busy, overrun);
    end
    run_frame(64'h0123_4567_89AB_CDEF, -1, 1'b0, 50);
    checks++;
    if (word !== 64'h0123_4567_89AB_CDEF || done_cyc !== FRAME_CYC || busy_err) begin
      errors++;
      $display("FAIL enable_drop_mid got=%h@%0d exp=%h@%0d", word, done_cyc,
               64'h0123_4567_89AB_CDEF, FRAME_CYC);
    end
  endtask

  task automatic test_capture();
    run_frame(64'hFEDC_BA98_7654_3210, -1, 1'b1, -1);
    checks++;
    if (word !== 64'hFEDC_BA98_7654_3210 || stable_err) begin
      errors++;
      $display("FAIL capture_hold got=%h stable_err=%0d exp=%h", word, stable_err,
               64'hFEDC_BA98_7654_3210);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
`ifdef TIMECODE_PARITY_EN
    test_parity();
`endif
    test_overrun();
    test_enable();
    test_capture();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
